// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes follow the Execute-stage muldiv field.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PREP = 2'b01,
        S_RUN  = 2'b10,
        S_FIX  = 2'b11
    } state_e;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// Operates on magnitudes; sign handling lives in the sequencer.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        sum    = {1'b0, acc_i} + {1'b0, d_i};
        rem_sh = {acc_i, q_i[WIDTH-1]};
        ge     = (rem_sh >= {1'b0, d_i});
        // when ge holds the true difference is below d, so WIDTH bits suffice
        diff   = rem_sh[WIDTH-1:0] - d_i;
        acc_o  = '0;
        q_o    = '0;
        if (div_i) begin
            acc_o = ge ? diff : rem_sh[WIDTH-1:0];
            q_o   = {q_i[WIDTH-2:0], ge};
        end else if (q_i[0]) begin
            acc_o = sum[WIDTH:1];
            q_o   = {sum[0], q_i[WIDTH-1:1]};
        end else begin
            acc_o = {1'b0, acc_i[WIDTH-1:1]};
            q_o   = {acc_i[0], q_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO registers.
// IDLE -> PREP -> RUN (WIDTH steps) -> FIX -> IDLE.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             Flush,
    input  logic             WriteHi,
    input  logic             WriteLo,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    state_e             state_q;
    op_e                op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   d_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   q_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;
    logic [WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]   q_d;
    logic               is_div;
    logic               is_signed;
    logic [2*WIDTH-1:0] prod;

    function automatic logic [WIDTH-1:0] mag(
        input logic [WIDTH-1:0] x,
        input logic             sgn
    );
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign is_signed = (op_q == OP_DIV) || (op_q == OP_MULT);
    assign prod      = {acc_q, q_q};

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_i (is_div),
        .acc_i (acc_q),
        .q_i   (q_q),
        .d_i   (d_q),
        .acc_o (acc_d),
        .q_o   (q_d)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            op_q      <= OP_MULT;
            a_q       <= '0;
            d_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (Flush && state_q != S_IDLE) begin
                state_q <= S_IDLE;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (Start && !Flush) begin
                            op_q    <= op_e'(Op);
                            a_q     <= OperandA;
                            d_q     <= OperandB;
                            state_q <= S_PREP;
                        end else if (!Start) begin
                            if (WriteHi) hi_q <= WriteData;
                            if (WriteLo) lo_q <= WriteData;
                        end
                    end
                    S_PREP: begin
                        q_q       <= mag(a_q, is_signed);
                        d_q       <= mag(d_q, is_signed);
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        neg_res_q <= is_signed & (a_q[WIDTH-1] ^ d_q[WIDTH-1]);
                        neg_rem_q <= is_signed & is_div & a_q[WIDTH-1];
                        state_q   <= S_RUN;
                    end
                    S_RUN: begin
                        acc_q <= acc_d;
                        q_q   <= q_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= S_FIX;
                    end
                    S_FIX: begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                        if (!is_div) begin
                            {hi_q, lo_q} <= neg_res_q ? -prod : prod;
                        end else if (d_q == '0) begin
                            // divide by zero keeps the raw dividend in HI
                            lo_q <= WIDTH'(DIV0_LO);
                            hi_q <= a_q;
                        end else begin
                            lo_q <= neg_res_q ? -q_q : q_q;
                            hi_q <= neg_rem_q ? -acc_q : acc_q;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign Busy = (state_q != S_IDLE);
    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule
